// File: rtl/seg14_scan_driver.sv
// Time-multiplexed 14-segment scan driver: one-hot digit select, writable message buffer,
// slot prescaler, frame-based horizontal scrolling and blanking. `SEG14_DIM_EN adds PWM dimming.
module seg14_scan_driver #(
    parameter int N_DIGITS      = 12,
    parameter int SEG_W         = 14,
    parameter int MSG_LEN       = 16,
    parameter int PRESCALE      = 1,
    parameter int SCROLL_FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [SEG_W-1:0]           wr_data,
    input  logic                       scroll_en,
    input  logic                       blank,
`ifdef SEG14_DIM_EN
    input  logic [2:0]                 bright,
`endif
    output logic [N_DIGITS-1:0]        sel,
    output logic [SEG_W-1:0]           segm,
    output logic                       frame_tick
);

    localparam int AW  = $clog2(MSG_LEN);
    localparam int AW1 = AW + 1;
    localparam int DW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [PW-1:0]  PS_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]  DG_LAST  = DW'(N_DIGITS - 1);
    localparam logic [FW-1:0]  FR_LAST  = FW'(SCROLL_FRAMES - 1);
    localparam logic [AW-1:0]  OFF_LAST = AW'(MSG_LEN - 1);
    localparam logic [AW1-1:0] ML       = AW1'(MSG_LEN);

    logic [PW-1:0]    pcnt;
    logic [DW-1:0]    digit;
    logic [AW-1:0]    offset;
    logic [FW-1:0]    frame_cnt;
    logic [SEG_W-1:0] mem [MSG_LEN];

    logic                slot_tick;
    logic                frame_end;
    logic                wr_ok;
    logic                show;
    logic [AW1-1:0]      rd_sum;
    logic [AW-1:0]       rd_idx;
    logic [N_DIGITS-1:0] sel_nxt;

    assign slot_tick = (pcnt == PS_LAST);
    assign frame_end = slot_tick && (digit == DG_LAST);
    assign wr_ok     = wr_en && ({1'b0, wr_addr} < ML);

    // offset + digit < 2*MSG_LEN, so a single conditional subtract reduces it
    assign rd_sum = {1'b0, offset} + AW1'(digit);
    assign rd_idx = (rd_sum >= ML) ? AW'(rd_sum - ML) : AW'(rd_sum);

    always_comb begin
        sel_nxt        = '0;
        sel_nxt[digit] = 1'b1;
    end

`ifdef SEG14_DIM_EN
    // On-time within a slot scales with bright in eighths of PRESCALE
    assign show = !blank && (int'(pcnt) < ((int'(bright) + 1) * PRESCALE) / 8);
`else
    assign show = !blank;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt       <= '0;
            digit      <= '0;
            offset     <= '0;
            frame_cnt  <= '0;
            sel        <= '0;
            segm       <= '0;
            frame_tick <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) mem[i] <= '0;
        end else begin
            pcnt <= slot_tick ? '0 : pcnt + 1'b1;
            if (slot_tick)
                digit <= (digit == DG_LAST) ? '0 : digit + 1'b1;

            if (frame_end && scroll_en) begin
                if (frame_cnt == FR_LAST) begin
                    frame_cnt <= '0;
                    offset    <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            // Read below sees the pre-edge contents, so a same-cycle write reads old data
            if (wr_ok) mem[wr_addr] <= wr_data;

            sel        <= sel_nxt;
            segm       <= show ? mem[rd_idx] : '0;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg14_scan_driver.sv
// Randomized bench for seg14_scan_driver: two instances (default and slow/odd-length) checked
// each cycle against a time-based reference model of digit, offset and buffer contents.
module tb_seg14_scan_driver;

`ifdef SEG14_DIM_EN
    localparam int PS0 = 8;
    localparam int PS1 = 9;
`else
    localparam int PS0 = 1;
    localparam int PS1 = 3;
`endif
    localparam int ML0 = 16, ML1 = 13;
    localparam int SF0 = 4,  SF1 = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [13:0] wr_data = '0;
    logic        scroll_en = 1'b0;
    logic        blank = 1'b0;
`ifdef SEG14_DIM_EN
    logic [2:0]  bright = 3'd7;
`endif

    logic [11:0] sel0, sel1;
    logic [13:0] segm0, segm1;
    logic        ft0, ft1;
    logic [26:0] obs [2];
    logic [26:0] exp_v [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg14_scan_driver #(.N_DIGITS(12), .SEG_W(14), .MSG_LEN(ML0), .PRESCALE(PS0), .SCROLL_FRAMES(SF0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_en(scroll_en), .blank(blank),
`ifdef SEG14_DIM_EN
        .bright(bright),
`endif
        .sel(sel0), .segm(segm0), .frame_tick(ft0));

    seg14_scan_driver #(.N_DIGITS(12), .SEG_W(14), .MSG_LEN(ML1), .PRESCALE(PS1), .SCROLL_FRAMES(SF1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .scroll_en(scroll_en), .blank(blank),
`ifdef SEG14_DIM_EN
        .bright(bright),
`endif
        .sel(sel1), .segm(segm1), .frame_tick(ft1));

    assign obs[0] = {sel0, segm0, ft0};
    assign obs[1] = {sel1, segm1, ft1};

    // Reference model: position derived from cycles since reset, offset from scrolled frames
    logic [13:0] mmem [2][16];
    int mcyc [2];
    int mfsc [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = 0; mfsc[i] = 0; exp_v[i] = '0;
            for (int a = 0; a < 16; a++) mmem[i][a] = '0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            int p, ml, sf, pc, dg, off;
            logic on;
            logic [13:0] pat;
            if (!rst_n) begin
                mcyc[i] = 0; mfsc[i] = 0; exp_v[i] = '0;
                for (int a = 0; a < 16; a++) mmem[i][a] = '0;
            end else begin
                p  = (i == 0) ? PS0 : PS1;
                ml = (i == 0) ? ML0 : ML1;
                sf = (i == 0) ? SF0 : SF1;
                pc  = mcyc[i] % p;
                dg  = (mcyc[i] / p) % 12;
                off = (mfsc[i] / sf) % ml;
                on  = !blank;
`ifdef SEG14_DIM_EN
                on  = on && (pc < ((int'(bright) + 1) * p) / 8);
`endif
                pat = on ? mmem[i][(off + dg) % ml] : 14'h0;
                exp_v[i] = {12'(1 << dg), pat, (pc == p - 1) && (dg == 11)};
                if ((pc == p - 1) && (dg == 11) && scroll_en) mfsc[i]++;
                if (wr_en && int'(wr_addr) < ml) mmem[i][wr_addr] = wr_data;
                mcyc[i]++;
            end
        end
    end

    task automatic test_reset();
        logic [26:0] first;
        first = {12'h001, 14'h0, 1'b0};
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 27'h0) begin
                errors++;
                $display("FAIL reset_hold u%0d got %h exp %h", i, obs[i], 27'h0);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs[0] !== 27'h0) begin
            errors++;
            $display("FAIL reset_release u0 got %h exp %h", obs[0], 27'h0);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== first) begin
                errors++;
                $display("FAIL reset_first u%0d got %h exp %h", i, obs[i], first);
            end
        end
    endtask

    task automatic test_scan();
        int last = -1;
        for (int k = 0; k < 24 * PS1 + 10; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL scan u%0d t=%0t got %h exp %h", i, $time, obs[i], exp_v[i]);
                end
            end
            if (ft1) begin
                if (last >= 0) begin
                    checks++;
                    if (k - last != 12 * PS1) begin
                        errors++;
                        $display("FAIL frame_period got %0d exp %0d", k - last, 12 * PS1);
                    end
                end
                last = k;
            end
        end
        checks++;
        if (last < 0) begin
            errors++;
            $display("FAIL frame_tick_seen got none exp pulse");
        end
    endtask

    task automatic test_pattern();
        logic [13:0] tbl [12];
        tbl = '{14'h3BC0, 14'h33C4, 14'h2412, 14'h2780, 14'h0700, 14'h0,
                14'h1E00, 14'h3BC0, 14'h0, 14'h2012, 14'h0, 14'h0};
        for (int k = 0; k < 12 + 40 * PS1; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL pattern u%0d t=%0t got %h exp %h", i, $time, obs[i], exp_v[i]);
                end
            end
            wr_en   = (k < 12);
            wr_addr = 4'(k % 12);
            wr_data = tbl[k % 12];
        end
        wr_en = 1'b0;
    endtask

    task automatic test_scroll();
        for (int k = 0; k < 16 + 64 * 12 * PS0 + 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL scroll u%0d t=%0t got %h exp %h", i, $time, obs[i], exp_v[i]);
                end
            end
            wr_en     = (k < 16);
            wr_addr   = 4'(k % 16);
            wr_data   = 14'($urandom);
            scroll_en = 1'b1;
        end
        wr_en = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL random u%0d t=%0t got %h exp %h", i, $time, obs[i], exp_v[i]);
                end
            end
            blank   = ($urandom_range(0, 3) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 14'($urandom);
            if (k % 50 == 0) scroll_en = $urandom_range(0, 1) == 1;
`ifdef SEG14_DIM_EN
            if (k % 40 == 0) bright = 3'($urandom);
`endif
        end
        blank = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 27'h0) begin
                errors++;
                $display("FAIL reset_mid u%0d got %h exp %h", i, obs[i], 27'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL after_reset u%0d t=%0t got %h exp %h", i, $time, obs[i], exp_v[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_pattern();
        test_scroll();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
